pwm_peripheral: RTL and testbench

Drives 16 output pins from the five configuration registers written over SPI: output enables, per-pin PWM enables and one shared 8-bit duty cycle. A prescaled 8-bit timebase generates a single PWM waveform at about 3 kHz (10 MHz clock). Each pin is then forced low, forced high or set to follow that waveform. The block sits directly downstream of the SPI register file and takes its register outputs as level inputs.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_timebase.sv | 47 ++++
 rtl/pwm_peripheral.sv | 88 ++++++++
 tb/tb_pwm_peripheral.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, types and the pin-mux helper for pwm_peripheral.
package pwm_pkg;

    localparam int         PWM_STEPS    = 255;
    localparam logic [7:0] PWM_STEP_MAX = 8'(PWM_STEPS - 1);
    localparam int         PIN_COUNT    = 16;

    typedef logic [7:0]           duty_t;
    typedef logic [PIN_COUNT-1:0] pinvec_t;

    // Per pin: disabled -> 0, enabled static -> 1, enabled PWM -> waveform.
    function automatic pinvec_t pin_mux(pinvec_t en_out, pinvec_t en_pwm, logic pwm);
        return en_out & (~en_pwm | {PIN_COUNT{pwm}});
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 255-step counter (0..254) shared by all pins.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] step,
    output logic       tick,
    output logic       wrap
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    step_q, step_d;

    // Next-state for the prescaler and the step counter.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        presc_d = presc_q + PW'(1);
        step_d  = step_q;
        tick    = (presc_q == PRESC_LAST);
        wrap    = tick && (step_q == PWM_STEP_MAX);
        if (tick) begin
            presc_d = '0;
            step_d  = wrap ? 8'd0 : step_q + 8'd1;
        end
    end

    // Counter registers; reset restarts the period at step 0.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            presc_q <= '0;
            step_q  <= '0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 pins forced low, forced high or following one shared PWM waveform.
// Optional macro PWM_DUTY_SHADOW_EN: latch the duty only at the period wrap so a
// mid-period write cannot truncate or stretch the pulse in flight.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] out_7_0,
    output logic [7:0] out_15_8,
    output logic       period_start
);

    pinvec_t    en_out;
    pinvec_t    en_pwm;
    logic [7:0] step;
    logic       tick_unused;  // the prescale tick is only consumed inside the timebase
    logic       wrap;
    duty_t      duty_active;
    logic       pwm;

    pinvec_t out_q, out_d;
    logic    period_start_q, period_start_d;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .tick  (tick_unused),
        .wrap  (wrap)
    );

`ifdef PWM_DUTY_SHADOW_EN
    duty_t duty_q, duty_d;

    // Shadow duty: pick up the written value only as a new period begins.
    always_comb begin
        duty_d = duty_q;
        if (wrap) duty_d = pwm_duty_cycle;
    end

    // Shadow register; the first period after reset runs at duty 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) duty_q <= '0;
        else        duty_q <= duty_d;
    end

    assign duty_active = duty_q;
`else
    assign duty_active = pwm_duty_cycle;
`endif

    // Waveform compare and pin muxing; step never exceeds 254, so duty 255 stays high.
    always_comb begin
        pwm            = (step < duty_active);
        out_d          = pin_mux(en_out, en_pwm, pwm);
        period_start_d = wrap;
    end

    // Registered pin drive and period marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q          <= '0;
            // NOTE: resets to 1 so the period that starts at reset release is flagged like any other.
            period_start_q <= 1'b1;
        end else begin
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out_7_0      = out_q[7:0];
    assign out_15_8     = out_q[15:8];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed stimulus with a scoreboard of cycle-exact and per-period expectations.
module tb_pwm_peripheral;
    import pwm_pkg::*;

    localparam int PRESCALE = 13;
    localparam int PER      = PRESCALE * 255;  // 3315 cycles per PWM period
`ifdef PWM_DUTY_SHADOW_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [7:0] out_7_0, out_15_8;
    logic       period_start;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out_7_0         (out_7_0),
        .out_15_8        (out_15_8),
        .period_start    (period_start)
    );

    typedef struct {
        int          at;
        logic [15:0] out;
        logic        chk_ps;
        logic        ps;
        string       name;
    } out_exp_t;

    typedef struct {
        int          at;        // cycle the period window must start on
        logic [15:0] pwm_mask;  // pins expected high for exactly 'hi' cycles
        logic [15:0] one_mask;  // pins expected high for the whole period
        int          hi;
        string       name;
    } win_exp_t;

    out_exp_t out_q[$];
    win_exp_t win_q[$];
    int checks = 0;
    int errors = 0;
    int tcnt   = 0;  // rising edges since time 0
    int rel;         // cycle at which reset was released

    always @(posedge clk) tcnt <= tcnt + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcnt);
        end
    endtask

    // Monitor: samples on the falling edge, pops cycle-exact expectations and
    // closes a measurement window at every period_start pulse.
    out_exp_t    e;
    win_exp_t    w;
    logic [15:0] o;
    int          win_start = -1;
    int          win_len;
    int          win_hi[16];
    int          exp_hi;

    always @(negedge clk) begin
        o = {out_15_8, out_7_0};
        while (out_q.size() > 0 && out_q[0].at <= tcnt) begin
            e = out_q.pop_front();
            if (e.at < tcnt) begin
                check({e.name, "_slot"}, 32'(tcnt), 32'(e.at));
            end else begin
                check(e.name, 32'(o), 32'(e.out));
                if (e.chk_ps) check({e.name, "_ps"}, 32'(period_start), 32'(e.ps));
            end
        end
        if (rst_n === 1'b1) begin
            if (period_start === 1'b1) begin
                if (win_start >= 0) begin
                    while (win_q.size() > 0 && win_q[0].at < win_start) begin
                        w = win_q.pop_front();
                        check({w.name, "_start"}, 32'(win_start), 32'(w.at));
                    end
                    if (win_q.size() > 0 && win_q[0].at == win_start) begin
                        w = win_q.pop_front();
                        check({w.name, "_len"}, 32'(win_len), 32'(PER));
                        for (int i = 0; i < 16; i++) begin
                            exp_hi = w.pwm_mask[i] ? w.hi : (w.one_mask[i] ? PER : 0);
                            check($sformatf("%s_pin%0d", w.name, i), 32'(win_hi[i]), 32'(exp_hi));
                        end
                    end
                end
                win_start = tcnt;
                win_len   = 0;
                for (int i = 0; i < 16; i++) win_hi[i] = 0;
            end
            win_len++;
            for (int i = 0; i < 16; i++) win_hi[i] += int'(o[i]);
        end
    end

    task automatic push_out(int at, logic [15:0] v, logic chk_ps, logic ps, string name);
        out_exp_t x;
        x.at = at; x.out = v; x.chk_ps = chk_ps; x.ps = ps; x.name = name;
        out_q.push_back(x);
    endtask

    task automatic push_win(int at, logic [15:0] pmask, logic [15:0] omask, int hi, string name);
        win_exp_t x;
        x.at = at; x.pwm_mask = pmask; x.one_mask = omask; x.hi = hi; x.name = name;
        win_q.push_back(x);
    endtask

    task automatic set_cfg(logic [15:0] eo, logic [15:0] ep, logic [7:0] duty);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
        pwm_duty_cycle = duty;
    endtask

    // Advance to just after the falling edge of cycle t.
    task automatic goto(int t);
        do @(negedge clk); while (tcnt < t);
        #1;
    endtask

    // First period_start cycle strictly after t.
    function automatic int next_ps(int t);
        return rel + PER * ((t - rel) / PER + 1);
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: bench exceeded its time limit at cycle %0d", tcnt);
        $fatal(1, "watchdog expired");
    end

    int w0, d0, d1, m0, s0, s2;

    initial begin
        rst_n = 1'b1;
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        #1 rst_n = 1'b0;
        for (int i = 1; i <= 5; i++) push_out(i, 16'h0000, 1'b1, 1'b1, "reset_hold");
        repeat (5) @(posedge clk);
        #1;
        rel   = tcnt;
        rst_n = 1'b1;
        set_cfg(16'h00A5, 16'h0000, 8'd0);
        push_out(rel,     16'h0000, 1'b1, 1'b1, "release");
        push_out(rel + 1, 16'h00A5, 1'b1, 1'b0, "static_lo");

        goto(rel + 1);
        set_cfg(16'h5A00, 16'h0000, 8'd0);
        push_out(rel + 2, 16'h5A00, 1'b1, 1'b0, "static_hi");
        goto(rel + 2);
        set_cfg(16'h0000, 16'hFFFF, 8'd255);
        push_out(rel + 3, 16'h0000, 1'b1, 1'b0, "pwm_without_oe");
        goto(rel + 3);
        set_cfg(16'hFFFF, 16'h0000, 8'd0);
        push_out(rel + 4, 16'hFFFF, 1'b1, 1'b0, "static_all");

        // 50% duty, three periods
        goto(rel + 4);
        set_cfg(16'hFFFF, 16'hFFFF, 8'd128);
        w0 = next_ps(tcnt) + SH * PER;
        push_out(w0 - 1,    16'h0000, 1'b1, 1'b0, "pre_period");
        push_out(w0,        16'h0000, 1'b1, 1'b1, "period_start");
        push_out(w0 + 1,    16'hFFFF, 1'b1, 1'b0, "duty128_rise");
        push_out(w0 + 1664, 16'hFFFF, 1'b0, 1'b0, "duty128_last_high");
        push_out(w0 + 1665, 16'h0000, 1'b0, 1'b0, "duty128_fall");
        for (int k = 0; k < 3; k++) push_win(w0 + k * PER, 16'hFFFF, 16'h0000, 1664, "duty128");

        // duty extremes
        goto(w0 + 3 * PER);
        set_cfg(16'hFFFF, 16'hFFFF, 8'd0);
        d0 = next_ps(tcnt) + SH * PER;
        push_win(d0, 16'hFFFF, 16'h0000, 0, "duty0");
        goto(d0 + PER);
        set_cfg(16'hFFFF, 16'hFFFF, 8'd255);
        d1 = next_ps(tcnt) + SH * PER;
        push_out(d1, 16'hFFFF, 1'b1, 1'b1, "duty255_start");
        push_win(d1, 16'hFFFF, 16'h0000, PER, "duty255");

        // mixed modes
        goto(d1 + PER);
        set_cfg(16'hFFFF, 16'h00F0, 8'd64);
        m0 = next_ps(tcnt) + SH * PER;
        push_win(m0, 16'h00F0, 16'hFF0F, 64 * PRESCALE, "mixed");

        // mid-period duty write 200 -> 10 at step 50
        goto(m0 + PER);
        set_cfg(16'hFFFF, 16'hFFFF, 8'd200);
        s0 = next_ps(tcnt);
        s2 = s0 + PER;
        push_out(s0 + 650, 16'hFFFF, 1'b0, 1'b0, "mid_before");
`ifdef PWM_DUTY_SHADOW_EN
        push_out(s0 + 2600, 16'hFFFF, 1'b0, 1'b0, "shadow_hold");
        push_out(s0 + 2601, 16'h0000, 1'b0, 1'b0, "shadow_fall");
`else
        push_out(s0 + 651, 16'h0000, 1'b0, 1'b0, "direct_fall");
`endif
        push_out(s2 + 130, 16'hFFFF, 1'b0, 1'b0, "duty10_last_high");
        push_out(s2 + 131, 16'h0000, 1'b0, 1'b0, "duty10_fall");
        push_win(s2, 16'hFFFF, 16'h0000, 10 * PRESCALE, "duty10");
        goto(s0 + 650);
        set_cfg(16'hFFFF, 16'hFFFF, 8'd10);

        goto(s2 + PER + 2);
        check("out_queue_drained", 32'(out_q.size()), 32'd0);
        check("win_queue_drained", 32'(win_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
